// File: rtl/permute_sequencer.sv
// rtl/permute_sequencer.sv - steps a permute block through num_files files with start pulse, finish handshake and timeout
module permute_sequencer #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [9:0] num_files,
    input  logic       perm_finish,
    output logic       perm_start,
    output logic [9:0] file_index,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [9:0] files_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_CLR,
        S_WAIT_FIN,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0]  PULSE_LAST = 4'(START_CYCLES - 1);
    localparam logic [16:0] TMO_LIMIT  = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic [9:0]  num_q, num_d;
    logic [9:0]  file_index_q, file_index_d;
    logic [9:0]  files_done_q, files_done_d;
    logic [3:0]  pulse_cnt_q, pulse_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        perm_start_q, perm_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_err_q, timeout_err_d;

    logic [16:0] tmo_inc;
    logic [9:0]  files_done_inc;

    assign tmo_inc        = {1'b0, tmo_cnt_q} + 17'd1;
    assign files_done_inc = files_done_q + 10'd1;

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        file_index_d  = file_index_q;
        files_done_d  = files_done_q;
        pulse_cnt_d   = pulse_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (go) begin
                    num_d         = num_files;
                    file_index_d  = 10'd0;
                    files_done_d  = 10'd0;
                    pulse_cnt_d   = 4'd0;
                    tmo_cnt_d     = 16'd0;
                    timeout_err_d = 1'b0;
                    state_d       = (num_files == 10'd0) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    tmo_cnt_d = 16'd0;
                    state_d   = S_WAIT_CLR;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 4'd1;
                end
            end
            // Timeout is tested before perm_finish so it wins on the same cycle.
            S_WAIT_CLR: begin
                tmo_cnt_d = tmo_inc[15:0];
                if (tmo_inc == TMO_LIMIT) begin
                    state_d = S_ERR;
                end else if (!perm_finish) begin
                    state_d = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                tmo_cnt_d = tmo_inc[15:0];
                if (tmo_inc == TMO_LIMIT) begin
                    state_d = S_ERR;
                end else if (perm_finish) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                files_done_d = files_done_inc;
                if (files_done_inc == num_q) begin
                    state_d = S_DONE;
                end else begin
                    file_index_d = file_index_q + 10'd1;
                    pulse_cnt_d  = 4'd0;
                    state_d      = S_PULSE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the next state so they line up with the state itself.
        perm_start_d = (state_d == S_PULSE);
        busy_d       = (state_d == S_PULSE) || (state_d == S_WAIT_CLR) ||
                       (state_d == S_WAIT_FIN) || (state_d == S_NEXT);
        done_d       = (state_d == S_DONE);
        if (state_d == S_ERR) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            num_q         <= 10'd0;
            file_index_q  <= 10'd0;
            files_done_q  <= 10'd0;
            pulse_cnt_q   <= 4'd0;
            tmo_cnt_q     <= 16'd0;
            perm_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            file_index_q  <= file_index_d;
            files_done_q  <= files_done_d;
            pulse_cnt_q   <= pulse_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            perm_start_q  <= perm_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign perm_start  = perm_start_q;
    assign file_index  = file_index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign files_done  = files_done_q;

endmodule

// File: tb/tb_permute_sequencer.sv
// tb/tb_permute_sequencer.sv - directed self-checking bench for permute_sequencer
module tb_permute_sequencer;

    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic [9:0] num_files = 10'd0;
    logic       perm_finish;
    logic       perm_start;
    logic [9:0] file_index;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [9:0] files_done;

    logic model_en  = 1'b1;
    logic model_fin = 1'b0;
    logic man_fin   = 1'b0;
    int   fin_cnt   = 0;
    int   stall_idx = 1023;

    int n_cmp = 0;
    int n_bad = 0;

    assign perm_finish = model_en ? model_fin : man_fin;

    permute_sequencer #(
        .START_CYCLES(START_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .num_files(num_files),
        .perm_finish(perm_finish),
        .perm_start(perm_start),
        .file_index(file_index),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err),
        .files_done(files_done)
    );

    always #5 clk = ~clk;

    // Permute model: drops finish on start, raises it 10 cycles after start ends unless stalled.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            model_fin = 1'b0;
            fin_cnt   = 0;
        end else if (perm_start) begin
            model_fin = 1'b0;
            fin_cnt   = 10;
        end else if (fin_cnt > 0) begin
            fin_cnt = fin_cnt - 1;
            if (fin_cnt == 0 && int'(file_index) != stall_idx) model_fin = 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_starts = 0, bad_len = 0, n_done = 0, busy_cycles = 0, run_len = 0;
    int   start_idx [2048];
    int   last_start_cyc = 0, err_cyc = 0, fin_rise_cyc = 0, done_cyc = 0;
    logic start_prev = 1'b0, err_prev = 1'b0, fin_prev = 1'b0, done_prev = 1'b0;

    always @(negedge clk) begin
        if (perm_start && !start_prev) begin
            start_idx[n_starts % 2048] = int'(file_index);
            n_starts = n_starts + 1;
            run_len  = 0;
        end
        if (perm_start) begin
            run_len        = run_len + 1;
            last_start_cyc = cyc;
        end else if (start_prev && run_len != START_CYCLES) begin
            bad_len = bad_len + 1;
        end
        if (done) n_done = n_done + 1;
        if (busy) busy_cycles = busy_cycles + 1;
        if (perm_finish && !fin_prev) fin_rise_cyc = cyc;
        if (done && !done_prev) done_cyc = cyc;
        if (timeout_err && !err_prev) err_cyc = cyc;
        start_prev = perm_start;
        fin_prev   = perm_finish;
        done_prev  = done;
        err_prev   = timeout_err;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        if (obs != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_go(input int n);
        go        = 1'b1;
        num_files = 10'(n);
        tick(1);
        go        = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, int'(done), 1);
    endtask

    int b, nd, bl, bc, k;

    initial begin
        tick(3);
        chk("rst_perm_start", int'(perm_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_file_index", int'(file_index), 0);
        chk("rst_files_done", int'(files_done), 0);
        rst = 1'b0;
        b = n_starts;
        tick(3);
        chk("idle_no_starts", n_starts - b, 0);
        chk("idle_busy", int'(busy), 0);

        // Three-file batch with responsive model
        b = n_starts; nd = n_done; bl = bad_len;
        do_go(3);
        chk("t1_start_latency", int'(perm_start), 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_first_index", int'(file_index), 0);
        wait_done("t1_done", 200);
        tick(2);
        chk("t1_done_latency", done_cyc - fin_rise_cyc, 2);
        chk("t1_starts", n_starts - b, 3);
        chk("t1_idx0", start_idx[b % 2048], 0);
        chk("t1_idx1", start_idx[(b + 1) % 2048], 1);
        chk("t1_idx2", start_idx[(b + 2) % 2048], 2);
        chk("t1_pulse_len", bad_len - bl, 0);
        chk("t1_files_done", int'(files_done), 3);
        chk("t1_file_index", int'(file_index), 2);
        chk("t1_done_pulses", n_done - nd, 1);
        chk("t1_timeout_err", int'(timeout_err), 0);
        chk("t1_busy_end", int'(busy), 0);

        // Empty batch
        b = n_starts; nd = n_done; bc = busy_cycles;
        do_go(0);
        chk("t2_done", int'(done), 1);
        chk("t2_perm_start", int'(perm_start), 0);
        tick(3);
        chk("t2_done_pulses", n_done - nd, 1);
        chk("t2_starts", n_starts - b, 0);
        chk("t2_busy_cycles", busy_cycles - bc, 0);
        chk("t2_files_done", int'(files_done), 0);

        // Stall on file 1 of 4, then recover with a new go
        stall_idx = 1;
        do_go(4);
        k = 0;
        while (!timeout_err && k < 400) begin
            tick(1);
            k++;
        end
        chk("t3_err_seen", int'(timeout_err), 1);
        tick(1);
        chk("t3_err_delay", err_cyc - last_start_cyc, TIMEOUT + 1);
        chk("t3_file_index", int'(file_index), 1);
        chk("t3_files_done", int'(files_done), 1);
        chk("t3_busy", int'(busy), 0);
        tick(3);
        chk("t3_err_sticky", int'(timeout_err), 1);
        stall_idx = 1023;
        do_go(2);
        chk("t3_err_cleared", int'(timeout_err), 0);
        chk("t3_busy_again", int'(busy), 1);
        wait_done("t3_done", 200);
        tick(2);
        chk("t3_files_done_end", int'(files_done), 2);
        chk("t3_file_index_end", int'(file_index), 1);

        // Stale finish held high across the start pulse
        model_en = 1'b0;
        man_fin  = 1'b1;
        nd = n_done;
        do_go(1);
        tick(2);
        chk("t4_start_end", int'(perm_start), 0);
        tick(3);
        chk("t4_hold_clr_files", int'(files_done), 0);
        chk("t4_hold_clr_busy", int'(busy), 1);
        man_fin = 1'b0;
        tick(3);
        chk("t4_hold_fin_files", int'(files_done), 0);
        chk("t4_hold_fin_busy", int'(busy), 1);
        man_fin = 1'b1;
        wait_done("t4_done", 20);
        chk("t4_files_done", int'(files_done), 1);
        tick(2);
        chk("t4_done_pulses", n_done - nd, 1);
        model_en = 1'b1;

        // Asynchronous reset during the start pulse of file 2
        do_go(3);
        k = 0;
        while (!(perm_start && file_index == 10'd2) && k < 200) begin
            tick(1);
            k++;
        end
        chk("t5_reached_file2", int'(perm_start && file_index == 10'd2), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_perm_start", int'(perm_start), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_file_index", int'(file_index), 0);
        chk("t5_async_files_done", int'(files_done), 0);
        chk("t5_async_done", int'(done), 0);
        tick(2);
        rst = 1'b0;
        b = n_starts;
        tick(4);
        chk("t5_quiet_after_rst", n_starts - b, 0);
        do_go(3);
        chk("t5_restart_index", int'(file_index), 0);
        chk("t5_restart_start", int'(perm_start), 1);
        wait_done("t5_done", 200);
        tick(2);
        chk("t5_files_done", int'(files_done), 3);

        // go and num_files disturbed mid-batch
        b = n_starts; nd = n_done;
        do_go(3);
        tick(4);
        go = 1'b1;
        num_files = 10'd5;
        tick(1);
        go = 1'b0;
        num_files = 10'd7;
        wait_done("t6_done", 200);
        tick(2);
        chk("t6_files_done", int'(files_done), 3);
        chk("t6_file_index", int'(file_index), 2);
        chk("t6_starts", n_starts - b, 3);
        chk("t6_done_pulses", n_done - nd, 1);

        // Largest batch: no wrap of index or count
        b = n_starts;
        do_go(1023);
        wait_done("t7_done", 20000);
        tick(2);
        chk("t7_file_index", int'(file_index), 1022);
        chk("t7_files_done", int'(files_done), 1023);
        chk("t7_starts", n_starts - b, 1023);
        chk("t7_last_idx", start_idx[(b + 1022) % 2048], 1022);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
